// File: rtl/rx_pkt_fifo_pkg.sv
// Shared types for the receive packet FIFO: Avalon-ST widths, the stored word and write FSM states.
package rx_pkt_fifo_pkg;

    localparam int AVLN_DATA_W  = 32;
    localparam int AVLN_EMPTY_W = 2;

    typedef struct packed {
        logic [AVLN_DATA_W-1:0]  data;
        logic                    sop;
        logic                    eop;
        logic [AVLN_EMPTY_W-1:0] empty;
    } pkt_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } rxf_state_t;

endpackage

// File: rtl/pkt_dp_ram.sv
// Simple dual-port RAM with one write port and a registered read port (block-RAM inferable).
// Read data holds its value whenever rd_en is low.
module pkt_dp_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/rx_pkt_fifo.sv
// Store-and-forward RX FIFO: frames are released only after a clean eop; errored, overflowing or mis-framed frames vanish.
// Statistics counters and overflow flag exist only when RX_PKT_FIFO_STATS_EN is defined.
module rx_pkt_fifo
    import rx_pkt_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_W      = 16
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic [AVLN_DATA_W-1:0]  in_data,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [AVLN_EMPTY_W-1:0] in_empty,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [5:0]              in_error,
    output logic [AVLN_DATA_W-1:0]  out_data,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [AVLN_EMPTY_W-1:0] out_empty,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        pkt_ok_cnt,
    output logic [CNT_W-1:0]        pkt_drop_cnt,
    output logic                    overflow_flag
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(1) << DEPTH_LOG2;

    rxf_state_t      state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic            accept, full, start_full, start;
    logic            wr_en, rd_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic            ok_inc, ovf_set;
    logic [1:0]      drop_n;
    pkt_word_t       wr_word, rd_word;

    assign accept     = in_valid & in_ready_q;
    // Fill uses the registered rd_ptr, so a same-cycle read never frees space for this write.
    assign full       = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign start_full = (commit_ptr_q - rd_ptr_q) == DEPTH_P;
    assign wr_word    = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q[DEPTH_LOG2-1:0];
        start        = 1'b0;
        ok_inc       = 1'b0;
        ovf_set      = 1'b0;
        drop_n       = 2'd0;
        if (accept) begin
            unique case (state_q)
                IDLE, DROP: begin
                    if (in_sop) begin
                        start = 1'b1;
                    end else if (in_eop) begin
                        state_d = IDLE;
                    end
                end
                RECV: begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_n   = 2'd1;
                        ovf_set  = 1'b1;
                        state_d  = in_eop ? IDLE : DROP;
                    end else if (in_sop) begin
                        drop_n = 2'd1;
                        start  = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (in_eop) begin
                            state_d = IDLE;
                            if (in_error != 6'd0) begin
                                wr_ptr_d = commit_ptr_q;
                                drop_n   = 2'd1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                ok_inc       = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            // A new frame always begins at commit_ptr, discarding any open partial frame.
            if (start) begin
                if (start_full) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_n   = drop_n + 2'd1;
                    ovf_set  = 1'b1;
                    state_d  = in_eop ? IDLE : DROP;
                end else begin
                    wr_en    = 1'b1;
                    wr_addr  = commit_ptr_q[DEPTH_LOG2-1:0];
                    wr_ptr_d = commit_ptr_q + 1'b1;
                    state_d  = RECV;
                    if (in_eop) begin
                        state_d = IDLE;
                        if (in_error != 6'd0) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_n   = drop_n + 2'd1;
                        end else begin
                            commit_ptr_d = commit_ptr_q + 1'b1;
                            ok_inc       = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // The RAM read register doubles as the output register; it only reloads on rd_en.
    always_comb begin
        rd_en       = (commit_ptr_q != rd_ptr_q) && (!out_valid_q || out_ready);
        rd_ptr_d    = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_valid_d = rd_en | (out_valid_q & ~out_ready);
        in_ready_d  = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    pkt_dp_ram #(
        .ADDR_W(DEPTH_LOG2),
        .DATA_W($bits(pkt_word_t))
    ) u_ram (
        .clk    (sys_clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_dat (wr_word),
        .rd_en  (rd_en),
        .rd_addr(rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_dat (rd_word)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = rd_word.data;
    assign out_sop   = rd_word.sop;
    assign out_eop   = rd_word.eop;
    assign out_empty = rd_word.empty;

`ifdef RX_PKT_FIFO_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_n);
        drop_cnt_d = (drop_sum > {1'b0, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
        ok_cnt_d   = ok_cnt_q;
        if (ok_inc && ok_cnt_q != CNT_MAX) begin
            ok_cnt_d = ok_cnt_q + 1'b1;
        end
        ovf_d = ovf_q | ovf_set;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pkt_ok_cnt    = ok_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;
    assign overflow_flag = ovf_q;
`else
    logic unused_stats;
    assign unused_stats  = ^{ok_inc, drop_n, ovf_set};
    assign pkt_ok_cnt    = '0;
    assign pkt_drop_cnt  = '0;
    assign overflow_flag = 1'b0;
`endif

endmodule
